csr_access_unit: RTL and testbench
==================================

// Module: csr_access_unit
// PURPOSE
//   Pipeline-side initiator for the CSR register file. Accepts one decoded Zicsr
//   instruction (CSRRW/S/C and immediate forms) per valid/ready handshake.
//   Runs a read-modify-write sequence on the CSR bus and returns the old CSR
//   value for rd. Suppresses writes as the ISA requires; flags illegal encodings
//   and writes to read-only CSRs. Sits between decode/execute and the CSR block.
// PARAMETERS
//   WORD_SIZE  32  datapath width; equals reg_t width
// PORTS
//   i_clk         in   1          clock, rising edge
//   i_rst         in   1          reset, asynchronous, active-high
//   i_valid       in   1          instruction request valid
//   o_ready       out  1          unit idle, request accepted when i_valid&o_ready
//   i_funct3      in   3          Zicsr funct3
//   i_csr_addr    in   12         target CSR address
//   i_rs1_data    in   WORD_SIZE  rs1 operand (register forms)
//   i_uimm        in   5          zimm / rs1 field
//   o_done        out  1          one-cycle completion pulse
//   o_rd_data     out  WORD_SIZE  old CSR value; valid while o_done=1
//   o_illegal     out  1          illegal-instruction flag; valid while o_done=1
//   o_csr_addr    out  12         CSR bus address
//   o_csr_re      out  1          CSR read strobe
//   i_csr_rd      in   WORD_SIZE  CSR read data, combinational from o_csr_addr
//   o_csr_we      out  1          CSR write strobe (one cycle)
//   o_csr_wd      out  WORD_SIZE  CSR write data, final value (not a mask)
// BEHAVIOUR
//   Reset: state=IDLE; o_ready=1; o_done, o_illegal, o_csr_re, o_csr_we = 0;
//     o_rd_data, o_csr_wd, o_csr_addr = 0. Reset mid-op aborts; no write issued.
//   FSM IDLE -> READ -> WRITE -> RESP -> IDLE; exactly 4 cycles per instruction.
//   IDLE: o_ready=1; on i_valid capture funct3, addr, operand, uimm; go READ.
//     Operand = funct3[2] ? {(WORD_SIZE-5)'0, i_uimm} : i_rs1_data.
//   READ: o_csr_re=1, o_csr_addr=captured addr; register i_csr_rd as old; go WRITE.
//   WRITE: funct3[1:0] 01: new=op; 10: new=old|op; 11: new=old&~op.
//     wr_req = (funct3[1:0]==01) | (i_uimm!=0).
//     illegal = funct3[1:0]==00 | (wr_req & addr[11:10]==2'b11).
//     o_csr_we=1 with o_csr_wd=new iff wr_req & ~illegal; o_csr_addr held; go RESP.
//   RESP: o_done=1; o_rd_data=old (0 if illegal); o_illegal=illegal; go IDLE.
//   o_ready=0 outside IDLE; i_valid ignored there. Back-to-back: next accept
//     on cycle after RESP. o_csr_re/o_csr_we never both high.
//   CSRRW with rd=x0 still reads (read side-effect-free CSRs); decode
//     handles rd suppression.
// TESTING
//   1 CSRRS mscratch(0x340)=0x0000_00F0, rs1=0x0F, uimm=1 -> we, wd=0xFF, rd=0xF0, done@+4.
//   2 CSRRC 0x340=0xFF, rs1=0x0F -> wd=0xF0, rd=0xFF.
//   3 CSRRSI uimm=0 on misa(0x301) -> no we pulse, rd=misa value, o_illegal=0.
//   4 CSRRW to 0xC00 -> o_illegal=1, o_csr_we never high, o_rd_data=0.
//   5 funct3=100 -> o_illegal=1, no write; o_ready low 3 cycles then high.
//   6 assert i_rst during WRITE -> we deasserts at once, IDLE, o_ready=1, CSR unchanged.

Source files
------------

// File: rtl/csr_access_unit.sv
// csr_access_unit
//   Pipeline-side initiator for the CSR register file. Takes one decoded Zicsr
//   instruction (CSRRW/CSRRS/CSRRC and their immediate forms) per valid/ready
//   handshake and runs a fixed read-modify-write sequence on the CSR bus:
//   IDLE -> READ -> WRITE -> RESP, four cycles per instruction. The old CSR
//   value is returned for rd. Writes are suppressed for set/clear forms with a
//   zero source field, and both reserved funct3 encodings and writes to
//   read-only CSRs (addr[11:10] == 2'b11) are reported as illegal.
//
// Ports
//   i_clk, i_rst          clock (rising edge), asynchronous active-high reset
//   i_valid / o_ready     request handshake; accepted when both are high
//   i_funct3              Zicsr funct3
//   i_csr_addr            target CSR address
//   i_rs1_data            rs1 operand for the register forms
//   i_uimm                zimm / rs1 field (also decides write suppression)
//   o_done                one-cycle completion pulse
//   o_rd_data, o_illegal  result and illegal flag, valid while o_done is high
//   o_csr_addr            CSR bus address
//   o_csr_re              CSR read strobe
//   i_csr_rd              CSR read data, combinational from o_csr_addr
//   o_csr_we, o_csr_wd    CSR write strobe and final write value
module csr_access_unit #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2:0]           i_funct3,
  input  logic [11:0]          i_csr_addr,
  input  logic [WORD_SIZE-1:0] i_rs1_data,
  input  logic [4:0]           i_uimm,
  output logic                 o_done,
  output logic [WORD_SIZE-1:0] o_rd_data,
  output logic                 o_illegal,
  output logic [11:0]          o_csr_addr,
  output logic                 o_csr_re,
  input  logic [WORD_SIZE-1:0] i_csr_rd,
  output logic                 o_csr_we,
  output logic [WORD_SIZE-1:0] o_csr_wd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           kind_q;     // funct3[1:0]: 01 write, 10 set, 11 clear
  logic [11:0]          addr_q;
  logic [WORD_SIZE-1:0] operand_q;
  logic [4:0]           uimm_q;
  logic [WORD_SIZE-1:0] old_q;

  logic                 wr_req;
  logic                 illegal;
  logic [WORD_SIZE-1:0] new_val;

  // The immediate/register choice is resolved at capture time, so only the
  // low two funct3 bits need to be kept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      kind_q    <= 2'b00;
      addr_q    <= 12'h000;
      operand_q <= '0;
      uimm_q    <= 5'd0;
      old_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && i_valid) begin
        kind_q    <= i_funct3[1:0];
        addr_q    <= i_csr_addr;
        operand_q <= i_funct3[2] ? {{(WORD_SIZE-5){1'b0}}, i_uimm} : i_rs1_data;
        uimm_q    <= i_uimm;
      end
      if (state_q == S_READ) begin
        old_q <= i_csr_rd;
      end
    end
  end

  // CSRRW always writes; set/clear forms write only with a non-zero source
  // field. The read-only check applies only when a write is actually wanted,
  // so reading a read-only CSR through CSRRS/CSRRC with x0 stays legal.
  assign wr_req  = (kind_q == 2'b01) || (uimm_q != 5'd0);
  assign illegal = (kind_q == 2'b00) || (wr_req && (addr_q[11:10] == 2'b11));

  always_comb begin
    new_val = operand_q;
    case (kind_q)
      2'b10:   new_val = old_q | operand_q;
      2'b11:   new_val = old_q & ~operand_q;
      default: new_val = operand_q;
    endcase
  end

  // The address is held from capture through RESP so the CSR block sees a
  // stable address for both the read and the write beat.
  assign o_csr_addr = addr_q;

  always_comb begin
    state_d   = state_q;
    o_ready   = 1'b0;
    o_done    = 1'b0;
    o_rd_data = '0;
    o_illegal = 1'b0;
    o_csr_re  = 1'b0;
    o_csr_we  = 1'b0;
    o_csr_wd  = '0;
    case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        o_csr_re = 1'b1;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        if (wr_req && !illegal) begin
          o_csr_we = 1'b1;
          o_csr_wd = new_val;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        o_done    = 1'b1;
        o_illegal = illegal;
        o_rd_data = illegal ? '0 : old_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_unit.sv
module tb_csr_access_unit;
  localparam int W = 32;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [2:0]    i_funct3 = 3'd0;
  logic [11:0]   i_csr_addr = 12'h000;
  logic [W-1:0]  i_rs1_data = '0;
  logic [4:0]    i_uimm = 5'd0;
  logic          o_ready, o_done, o_illegal, o_csr_re, o_csr_we;
  logic [W-1:0]  o_rd_data, o_csr_wd, i_csr_rd;
  logic [11:0]   o_csr_addr;

  csr_access_unit #(.WORD_SIZE(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_funct3(i_funct3), .i_csr_addr(i_csr_addr), .i_rs1_data(i_rs1_data),
    .i_uimm(i_uimm), .o_done(o_done), .o_rd_data(o_rd_data),
    .o_illegal(o_illegal), .o_csr_addr(o_csr_addr), .o_csr_re(o_csr_re),
    .i_csr_rd(i_csr_rd), .o_csr_we(o_csr_we), .o_csr_wd(o_csr_wd)
  );

  always #5 i_clk = ~i_clk;

  // CSR block stand-in: combinational read, write on the clock edge.
  logic [W-1:0] csr_mem [0:4095];
  logic         pre_en = 1'b0;
  logic [11:0]  pre_addr = 12'h000;
  logic [W-1:0] pre_data = '0;
  assign i_csr_rd = csr_mem[o_csr_addr];
  always @(posedge i_clk) begin
    if (pre_en) csr_mem[pre_addr] <= pre_data;
    else if (o_csr_we) csr_mem[o_csr_addr] <= o_csr_wd;
  end

  // Reference CSR contents, updated only by the model.
  logic [W-1:0] ref_csr [0:4095];

  int n_cmp = 0;
  int n_err = 0;

  // Observations of one instruction, filled by run_op.
  logic [W-1:0] obs_rd, obs_wd;
  logic [11:0]  obs_waddr;
  logic         obs_ill, obs_ready_after;
  int           obs_we_cnt, obs_re_cnt, obs_done_cyc, obs_ready_low, obs_both;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [11:0] a, input logic [W-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge i_clk);
    pre_en = 1'b0;
    ref_csr[a] = d;
  endtask

  // Behavioural model of one instruction from the ISA rules.
  task automatic ref_op(input logic [2:0] f3, input logic [11:0] a,
                        input logic [W-1:0] rs1, input logic [4:0] u,
                        output logic [W-1:0] e_rd, output logic e_ill,
                        output logic e_wr, output logic [W-1:0] e_wd);
    logic [W-1:0] src, old;
    logic wants_write, read_only;
    old = ref_csr[a];
    src = f3[2] ? {{(W-5){1'b0}}, u} : rs1;
    wants_write = (f3[1:0] == 2'b01) || (u != 5'd0);
    read_only = (a >= 12'hC00);
    e_ill = (f3[1:0] == 2'b00) || (wants_write && read_only);
    e_wr = wants_write && !e_ill;
    if (f3[1:0] == 2'b01) e_wd = src;
    else if (f3[1:0] == 2'b10) e_wd = old | src;
    else if (f3[1:0] == 2'b11) e_wd = old & ~src;
    else e_wd = '0;
    e_rd = e_ill ? '0 : old;
    if (e_wr) ref_csr[a] = e_wd;
  endtask

  // Issues one instruction starting just after a falling edge and observes
  // the four following cycles; with noise set, i_valid stays high with junk
  // fields while busy. Returns just after the falling edge of the IDLE cycle.
  task automatic run_op(input logic [2:0] f3, input logic [11:0] a,
                        input logic [W-1:0] rs1, input logic [4:0] u,
                        input bit noise);
    int guard = 0;
    obs_rd = '0; obs_wd = '0; obs_waddr = '0; obs_ill = 1'b0;
    obs_we_cnt = 0; obs_re_cnt = 0; obs_done_cyc = 0; obs_ready_low = 0;
    obs_both = 0; obs_ready_after = 1'b0;
    while (!o_ready && guard < 20) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_ready) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout: o_ready=%0b required 1", o_ready);
    end
    i_valid = 1'b1; i_funct3 = f3; i_csr_addr = a; i_rs1_data = rs1; i_uimm = u;
    @(negedge i_clk);
    for (int c = 1; c <= 4; c++) begin
      if (noise && c < 4) begin
        i_valid = 1'b1;
        i_funct3 = 3'($urandom); i_csr_addr = 12'($urandom);
        i_rs1_data = $urandom; i_uimm = 5'($urandom);
      end else begin
        i_valid = 1'b0;
      end
      if (o_csr_re && o_csr_we) obs_both++;
      if (o_csr_re) obs_re_cnt++;
      if (o_csr_we) begin
        obs_we_cnt++; obs_wd = o_csr_wd; obs_waddr = o_csr_addr;
      end
      if (c < 4 && !o_ready) obs_ready_low++;
      if (c == 4) obs_ready_after = o_ready;
      if (o_done && obs_done_cyc == 0) begin
        obs_done_cyc = c; obs_rd = o_rd_data; obs_ill = o_illegal;
      end
      if (c < 4) @(negedge i_clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b want 1", o_ready); end
    n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", o_done); end
    n_cmp++; if (o_illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal: got %0b want 0", o_illegal); end
    n_cmp++; if (o_csr_re !== 1'b0 || o_csr_we !== 1'b0) begin n_err++; $display("FAIL reset_strobes: re=%0b we=%0b want 0 0", o_csr_re, o_csr_we); end
    n_cmp++; if (o_rd_data !== '0 || o_csr_wd !== '0 || o_csr_addr !== 12'h000) begin
      n_err++; $display("FAIL reset_data: rd=%h wd=%h addr=%h want 0 0 0", o_rd_data, o_csr_wd, o_csr_addr);
    end
    $display("reset: ready=%0b done=%0b addr=%h", o_ready, o_done, o_csr_addr);
  endtask

  task automatic test_directed;
    // 1: CSRRS mscratch
    preload(12'h340, 32'h0000_00F0);
    run_op(3'b010, 12'h340, 32'h0000_000F, 5'd1, 1'b0);
    $display("csrrs: we=%0d wd=%h rd=%h done@%0d", obs_we_cnt, obs_wd, obs_rd, obs_done_cyc);
    n_cmp++; if (obs_we_cnt != 1 || obs_wd !== 32'hFF || obs_waddr !== 12'h340) begin
      n_err++; $display("FAIL csrrs_write: we=%0d wd=%h addr=%h want 1 000000ff 340", obs_we_cnt, obs_wd, obs_waddr);
    end
    n_cmp++; if (obs_rd !== 32'hF0 || obs_ill !== 1'b0) begin n_err++; $display("FAIL csrrs_rd: rd=%h ill=%0b want 000000f0 0", obs_rd, obs_ill); end
    n_cmp++; if (obs_done_cyc != 3 || obs_re_cnt != 1) begin n_err++; $display("FAIL csrrs_timing: done@%0d re=%0d want 3 1", obs_done_cyc, obs_re_cnt); end
    // 2: CSRRC
    run_op(3'b011, 12'h340, 32'h0000_000F, 5'd1, 1'b0);
    $display("csrrc: we=%0d wd=%h rd=%h", obs_we_cnt, obs_wd, obs_rd);
    n_cmp++; if (obs_we_cnt != 1 || obs_wd !== 32'hF0 || obs_rd !== 32'hFF) begin
      n_err++; $display("FAIL csrrc: we=%0d wd=%h rd=%h want 1 000000f0 000000ff", obs_we_cnt, obs_wd, obs_rd);
    end
    // 3: CSRRSI with zero immediate on misa: pure read
    preload(12'h301, 32'h4000_1104);
    run_op(3'b110, 12'h301, 32'hFFFF_FFFF, 5'd0, 1'b0);
    $display("csrrsi0: we=%0d rd=%h ill=%0b", obs_we_cnt, obs_rd, obs_ill);
    n_cmp++; if (obs_we_cnt != 0 || obs_rd !== 32'h4000_1104 || obs_ill !== 1'b0) begin
      n_err++; $display("FAIL csrrsi_zero: we=%0d rd=%h ill=%0b want 0 40001104 0", obs_we_cnt, obs_rd, obs_ill);
    end
    // 4: CSRRW to read-only cycle counter
    preload(12'hC00, 32'h1234_0000);
    run_op(3'b001, 12'hC00, 32'hDEAD_BEEF, 5'd3, 1'b0);
    $display("csrrw_ro: we=%0d rd=%h ill=%0b", obs_we_cnt, obs_rd, obs_ill);
    n_cmp++; if (obs_we_cnt != 0 || obs_rd !== '0 || obs_ill !== 1'b1) begin
      n_err++; $display("FAIL csrrw_readonly: we=%0d rd=%h ill=%0b want 0 0 1", obs_we_cnt, obs_rd, obs_ill);
    end
    // 5: reserved funct3 = 100
    run_op(3'b100, 12'h340, 32'h0, 5'd7, 1'b0);
    $display("funct3_100: we=%0d ill=%0b ready_low=%0d ready_after=%0b", obs_we_cnt, obs_ill, obs_ready_low, obs_ready_after);
    n_cmp++; if (obs_we_cnt != 0 || obs_ill !== 1'b1) begin n_err++; $display("FAIL funct3_reserved: we=%0d ill=%0b want 0 1", obs_we_cnt, obs_ill); end
    n_cmp++; if (obs_ready_low != 3 || obs_ready_after !== 1'b1) begin
      n_err++; $display("FAIL ready_window: low=%0d after=%0b want 3 1", obs_ready_low, obs_ready_after);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [W-1:0] e_rd, e_wd;
    logic e_ill, e_wr;
    preload(12'h340, 32'h1234_5678);
    i_valid = 1'b1; i_funct3 = 3'b001; i_csr_addr = 12'h340; i_rs1_data = 32'hAAAA_5555; i_uimm = 5'd2;
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (o_csr_we !== 1'b1) begin n_err++; $display("FAIL midop_in_write: we=%0b want 1", o_csr_we); end
    #1 i_rst = 1'b1;
    #1;
    $display("midop_reset: we=%0b ready=%0b done=%0b", o_csr_we, o_ready, o_done);
    n_cmp++; if (o_csr_we !== 1'b0 || o_ready !== 1'b1 || o_done !== 1'b0) begin
      n_err++; $display("FAIL midop_abort: we=%0b ready=%0b done=%0b want 0 1 0", o_csr_we, o_ready, o_done);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++; if (csr_mem[12'h340] !== 32'h1234_5678 || o_ready !== 1'b1) begin
      n_err++; $display("FAIL midop_csr_kept: csr=%h ready=%0b want 12345678 1", csr_mem[12'h340], o_ready);
    end
    ref_op(3'b010, 12'h340, 32'h0, 5'd0, e_rd, e_ill, e_wr, e_wd);
    run_op(3'b010, 12'h340, 32'h0, 5'd0, 1'b0);
    n_cmp++; if (obs_rd !== e_rd || obs_we_cnt != 0) begin
      n_err++; $display("FAIL midop_recover: rd=%h we=%0d want %h 0", obs_rd, obs_we_cnt, e_rd);
    end
  endtask

  // Random instructions issued back to back, half of them with i_valid held
  // high and junk fields while the unit is busy.
  task automatic test_back_to_back;
    logic [11:0] addrs [0:7];
    logic [W-1:0] e_rd, e_wd, rs1;
    logic e_ill, e_wr;
    logic [2:0] f3;
    logic [4:0] u;
    logic [11:0] a;
    bit noise;
    addrs[0] = 12'h340; addrs[1] = 12'h341; addrs[2] = 12'h300; addrs[3] = 12'h301;
    addrs[4] = 12'hC00; addrs[5] = 12'hC01; addrs[6] = 12'hF11; addrs[7] = 12'h7C0;
    for (int i = 0; i < 8; i++) preload(addrs[i], $urandom);
    for (int n = 0; n < 40; n++) begin
      a = addrs[$urandom_range(0, 7)];
      f3 = 3'($urandom_range(0, 7));
      u = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rs1 = $urandom;
      noise = ($urandom_range(0, 1) == 1);
      ref_op(f3, a, rs1, u, e_rd, e_ill, e_wr, e_wd);
      run_op(f3, a, rs1, u, noise);
      $display("op%0d: f3=%b addr=%h rs1=%h u=%0d noise=%0b -> we=%0d wd=%h rd=%h ill=%0b",
               n, f3, a, rs1, u, noise, obs_we_cnt, obs_wd, obs_rd, obs_ill);
      n_cmp++; if (obs_rd !== e_rd || obs_ill !== e_ill) begin
        n_err++; $display("FAIL rand_result op%0d: rd=%h ill=%0b want %h %0b", n, obs_rd, obs_ill, e_rd, e_ill);
      end
      n_cmp++; if (obs_we_cnt != (e_wr ? 1 : 0) || (e_wr && (obs_wd !== e_wd || obs_waddr !== a))) begin
        n_err++; $display("FAIL rand_write op%0d: we=%0d wd=%h addr=%h want %0d %h %h", n, obs_we_cnt, obs_wd, obs_waddr, e_wr ? 1 : 0, e_wd, a);
      end
      n_cmp++; if (obs_done_cyc != 3 || obs_ready_low != 3 || obs_ready_after !== 1'b1 || obs_re_cnt != 1 || obs_both != 0) begin
        n_err++; $display("FAIL rand_protocol op%0d: done@%0d low=%0d after=%0b re=%0d both=%0d want 3 3 1 1 0",
                          n, obs_done_cyc, obs_ready_low, obs_ready_after, obs_re_cnt, obs_both);
      end
      n_cmp++; if (csr_mem[a] !== ref_csr[a]) begin
        n_err++; $display("FAIL rand_csr op%0d: csr[%h]=%h want %h", n, a, csr_mem[a], ref_csr[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
